serial_subtractor: RTL



---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/full_subtractor.sv | 31 +++
 rtl/serial_subtractor.sv | 118 +++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | serial_sub_pkg : shared width default and FSM state encoding   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  // 2'd3 is unused and recovers to IDLE.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------+
// | full_subtractor : 1-bit gate-level full subtractor cell        |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  wire x_xor_y;
  wire x_n;
  wire xy_n;
  wire brw_gen;
  wire brw_prop;

  xor u_xor_xy  (x_xor_y, x, y);
  xor u_xor_d   (d, x_xor_y, bin);

  // Borrow generated when x=0,y=1; propagated when x==y and a borrow comes in.
  not u_not_x   (x_n, x);
  and u_and_gen (brw_gen, x_n, y);
  not u_not_xy  (xy_n, x_xor_y);
  and u_and_prp (brw_prop, xy_n, bin);
  or  u_or_bout (bout, brw_gen, brw_prop);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------+
// | serial_subtractor : bit-serial A-B, LSB first, valid/ready I/O |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int             CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;

  logic             fs_d;
  logic             fs_bout;

  full_subtractor u_cell (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d      = state_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    sd_d         = sd_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sa_d     = a;
          sb_d     = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        sd_d     = {fs_d, sd_q[WIDTH-1:1]};
        borrow_d = fs_bout;
        cnt_d    = cnt_q + 1'b1;
        // Last bit: publish the result including the bit computed now.
        if (cnt_q == LAST_BIT) begin
          diff_d       = {fs_d, sd_q[WIDTH-1:1]};
          borrow_out_d = fs_bout;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sa_q         <= '0;
      sb_q         <= '0;
      sd_q         <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      sd_q         <= sd_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule
`default_nettype wire
